note_chart_sequencer: RTL and testbench
=======================================

Name: note_chart_sequencer

Overview:
- Sequences playback of the note-chart ROM: one 4-bit lane row per beat, consumed by the falling-note renderer and hit judge.
- Owns the ROM address bus and the beat timebase. Compensates the ROM's 1-cycle registered read latency.
- Publishes each row with a single-cycle valid strobe and its chart index; supports start, pause and end-of-chart.

Parameters:
- BEAT_DIV, 12500000, clocks per chart row (min 4); 50 MHz / 12.5M = 4 rows/s
- CHART_LEN, 274, number of rows in chart; last index CHART_LEN-1
- ADDR_W, 13, ROM address / index width

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- start  in  1  level-sampled start request; acted on only in IDLE or DONE
- pause  in  1  level; high freezes beat timebase and index
- rom_addr  out  ADDR_W  registered address to note ROM
- rom_data  in  4  ROM read data, valid 1 clk after rom_addr is sampled
- row  out  4  latched lane row; bit3..bit0 = lane 0..3
- row_valid  out  1  one-cycle strobe: row/row_index updated
- row_index  out  ADDR_W  chart index of current row
- busy  out  1  high in RUN, FETCH, CAPTURE
- done  out  1  high in DONE

Behaviour:
- Reset (resetn=0 at posedge), overriding all else, including mid-fetch:
  - state=IDLE; rom_addr=0, row=0, row_valid=0, row_index=0, busy=0, done=0.
  - Internal beat_cnt=0, idx=0.
- States: IDLE, RUN, FETCH, CAPTURE, DONE.
- IDLE: start=1 -> idx=0, beat_cnt=0, state=RUN.
- RUN:
  - pause=1 -> hold beat_cnt and idx.
  - Else, beat_cnt<BEAT_DIV-1 -> beat_cnt+1.
  - beat_cnt==BEAT_DIV-1 -> beat_cnt=0, rom_addr<=idx, state=FETCH.
- FETCH: ROM samples rom_addr this edge; state=CAPTURE. Not affected by pause.
- CAPTURE (not affected by pause):
  - row<=rom_data, row_index<=idx, row_valid=1 for exactly one cycle.
  - idx==CHART_LEN-1 -> state=DONE; else idx+1, state=RUN.
- Latency: row_valid is high in the 3rd cycle after the terminal-count edge. beat_cnt runs during FETCH/CAPTURE, so row spacing is exactly BEAT_DIV clocks when unpaused.
- Pause behaviour:
  - Pause asserted while a fetch is in flight lets the fetch complete; the next beat is then frozen.
  - Pause low resumes from the held beat_cnt, with no lost or extra rows.
- Zero rows (4'b0000) are emitted normally with row_valid=1; the sequencer does not filter.
- DONE: row held, row_valid=0, done=1. start=1 -> restart as from IDLE (idx=0, beat_cnt=0, RUN).
- start in RUN/FETCH/CAPTURE is ignored; start and pause together in IDLE/DONE -> start taken, pause then applies in RUN.
- Width rules: idx increments never exceed CHART_LEN-1; rom_addr always < CHART_LEN.

Optional Feature:
- Macro: NOTE_CHART_LOOP_EN.
- Defined:
  - Adds parameter LOOP_START (default 4, first non-lead-in row).
  - CAPTURE at idx==CHART_LEN-1 sets idx=LOOP_START and returns to RUN.
  - DONE is never entered; done stays 0.
- Undefined: end-of-chart behaviour as in Behaviour; no LOOP_START parameter.

Test Plan:
- Reset mid-FETCH with BEAT_DIV=4, CHART_LEN=8 and a model ROM (row k = k[3:0]) -> next cycle state IDLE, all outputs 0, no row_valid.
- start pulse, no pause -> 8 row_valid strobes spaced exactly 4 clks, row=0..7, row_index=0..7. First strobe at clk 3 after the first terminal count. Then done=1, busy=0.
- Check rom_addr vs row -> each row equals ROM[rom_addr] issued 2 edges earlier (verifies 1-cycle ROM latency).
- pause high for 10 clks starting the cycle after row 2 is fetched -> row 2 still strobes. Row 3 is delayed by exactly 10 clks; total strobes still 8.
- start while busy at row 4 -> ignored, sequence continues 5,6,7. start in DONE -> restarts at row_index 0.
- With NOTE_CHART_LOOP_EN, LOOP_START=4 -> row_index sequence 0..7,4..7,4..; done never asserts.

Source files
------------

// File: rtl/note_chart_sequencer.sv
// Note-chart playback sequencer: paces one 4-bit lane row per beat out of a registered-read ROM.
// Optional macro NOTE_CHART_LOOP_EN: wrap to LOOP_START after the last row instead of stopping.
module note_chart_sequencer #(
  parameter int BEAT_DIV  = 12500000,
  parameter int CHART_LEN = 274,
  parameter int ADDR_W    = 13
`ifdef NOTE_CHART_LOOP_EN
  ,
  parameter int LOOP_START = 4
`endif
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        row,
  output logic              row_valid,
  output logic [ADDR_W-1:0] row_index,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BEAT_DIV - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(CHART_LEN - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  beat_cnt;
  logic [ADDR_W-1:0] idx;

  assign busy = (state == S_RUN) || (state == S_FETCH) || (state == S_CAPTURE);
  assign done = (state == S_DONE);

  // NOTE: every register here is assigned with <= so all of them update from the
  // same pre-edge values; a blocking = would let later statements see new values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      idx       <= '0;
      rom_addr  <= '0;
      row       <= '0;
      row_valid <= 1'b0;
      row_index <= '0;
    end else begin
      row_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx      <= '0;
            beat_cnt <= '0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (!pause) begin
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt <= '0;
              rom_addr <= idx;
              state    <= S_FETCH;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        S_FETCH: begin
          // The beat keeps counting through the fetch so rows stay BEAT_DIV apart.
          if (!pause) beat_cnt <= beat_cnt + CNT_W'(1);
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (!pause) beat_cnt <= beat_cnt + CNT_W'(1);
          row       <= rom_data;
          row_index <= idx;
          row_valid <= 1'b1;
          if (idx == IDX_LAST) begin
`ifdef NOTE_CHART_LOOP_EN
            idx   <= ADDR_W'(LOOP_START);
            state <= S_RUN;
`else
            state <= S_DONE;
`endif
          end else begin
            idx   <= idx + ADDR_W'(1);
            state <= S_RUN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_chart_sequencer.sv
// Self-checking bench for note_chart_sequencer: beat-count reference model, directed
// scenarios with literal timing expectations, then a randomized start/pause/reset soak.
module tb_note_chart_sequencer;

  localparam int BEAT_DIV  = 4;
  localparam int CHART_LEN = 8;
  localparam int ADDR_W    = 13;
`ifdef NOTE_CHART_LOOP_EN
  localparam int LOOP_START = 4;
`endif

  logic              clk = 1'b0;
  logic              resetn, start, pause;
  logic [ADDR_W-1:0] rom_addr, row_index;
  logic [3:0]        rom_data, row;
  logic              row_valid, busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  note_chart_sequencer #(
    .BEAT_DIV (BEAT_DIV),
    .CHART_LEN(CHART_LEN),
    .ADDR_W   (ADDR_W)
`ifdef NOTE_CHART_LOOP_EN
    ,
    .LOOP_START(LOOP_START)
`endif
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .pause    (pause),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .row      (row),
    .row_valid(row_valid),
    .row_index(row_index),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Note ROM with one-clock registered read.
  logic [3:0] rom_mem [0:CHART_LEN-1];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Reference model: a fetch is issued on every BEAT_DIV-th unpaused busy edge,
  // and its row is published two edges later regardless of pause.
  bit         m_known = 1'b0;
  bit         m_active = 1'b0, m_done = 1'b0, m_pend = 1'b0;
  int         m_ticks = 0, m_next = 0, m_pend_idx = 0, m_pend_age = 0;
  logic [3:0]        e_row;
  logic [ADDR_W-1:0] e_addr, e_index;
  logic              e_valid;

  always @(posedge clk) begin : model
    bit was_active;
    if (resetn === 1'b0) begin
      m_known  = 1'b1;
      m_active = 1'b0;
      m_done   = 1'b0;
      m_pend   = 1'b0;
      m_ticks  = 0;
      m_next   = 0;
      e_row    = '0;
      e_addr   = '0;
      e_index  = '0;
      e_valid  = 1'b0;
    end else if (m_known) begin
      was_active = m_active;
      e_valid    = 1'b0;
      if (m_pend) begin
        m_pend_age++;
        if (m_pend_age == 2) begin
          m_pend  = 1'b0;
          e_valid = 1'b1;
          e_row   = rom_mem[m_pend_idx];
          e_index = ADDR_W'(m_pend_idx);
          if (m_pend_idx == CHART_LEN - 1) begin
`ifdef NOTE_CHART_LOOP_EN
            m_next = LOOP_START;
`else
            m_active = 1'b0;
            m_done   = 1'b1;
`endif
          end else begin
            m_next = m_pend_idx + 1;
          end
        end
      end
      if (was_active && !pause) begin
        m_ticks++;
        if (m_ticks % BEAT_DIV == 0) begin
          m_pend     = 1'b1;
          m_pend_age = 0;
          m_pend_idx = m_next;
          e_addr     = ADDR_W'(m_next);
        end
      end
      if (!was_active && start) begin
        m_active = 1'b1;
        m_done   = 1'b0;
        m_ticks  = 0;
        m_next   = 0;
      end
    end
  end

  // Compare process: every negedge once reset has been seen.
  logic [ADDR_W-1:0] addr_h1 = '0, addr_h2 = '0;
  time st_time[$];
  int  st_index[$];
  int  st_row[$];

  always @(negedge clk) begin
    if (m_known) begin
      check("row", row, e_row);
      check("row_valid", row_valid, e_valid);
      check("row_index", row_index, e_index);
      check("rom_addr", rom_addr, e_addr);
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("addr_range", rom_addr < ADDR_W'(CHART_LEN), 1);
      if (row_valid === 1'b1) begin
        check("rom_latency", row, rom_mem[addr_h2]);
        st_time.push_back($time);
        st_index.push_back(int'(row_index));
        st_row.push_back(int'(row));
      end
      addr_h2 = addr_h1;
      addr_h1 = rom_addr;
    end
  end

  task automatic clear_log();
    st_time.delete();
    st_index.delete();
    st_row.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", done, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    time t0;
    int  n;
    resetn = 1'b0;
    start  = 1'b0;
    pause  = 1'b0;
    for (int k = 0; k < CHART_LEN; k++) rom_mem[k] = 4'(k);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", rom_addr, 0);
    resetn = 1'b1;
    @(negedge clk);

`ifdef NOTE_CHART_LOOP_EN
    clear_log();
    pulse_start();
    n = 0;
    while (st_index.size() < 20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("loop_count", st_index.size() >= 20, 1);
    for (int i = 0; i < 20 && i < st_index.size(); i++)
      check("loop_index", st_index[i], (i < 8) ? i : 4 + ((i - 8) % 4));
    check("loop_no_done", done, 0);
    check("loop_busy", busy, 1);
`else
    // Plain run: 8 rows, 4 clocks apart, first row 6 edges after the start edge.
    clear_log();
    t0 = $time;
    pulse_start();
    wait_done(200);
    check("a_strobes", st_index.size(), 8);
    if (st_time.size() > 0) check("a_first_latency", 32'(st_time[0] - t0), 70);
    for (int i = 0; i < st_index.size(); i++) begin
      check("a_index", st_index[i], i);
      check("a_row", st_row[i], i);
      if (i > 0) check("a_spacing", 32'(st_time[i] - st_time[i-1]), 40);
    end
    check("a_done", done, 1);
    check("a_busy", busy, 0);

    // Restart from DONE, pause across the row-2 fetch, start ignored while busy.
    clear_log();
    t0 = $time;
    pulse_start();
    n = 0;
    while (rom_addr !== ADDR_W'(2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b_fetch2_seen", rom_addr, 2);
    pause = 1'b1;
    repeat (10) @(negedge clk);
    pause = 1'b0;
    n = 0;
    while (!(row_valid === 1'b1 && row_index === ADDR_W'(4)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b_row4_seen", row_index, 4);
    pulse_start();
    wait_done(300);
    check("b_strobes", st_index.size(), 8);
    if (st_time.size() > 0) check("b_first_latency", 32'(st_time[0] - t0), 70);
    for (int i = 0; i < st_index.size(); i++) begin
      check("b_index", st_index[i], i);
      if (i > 0) check("b_spacing", 32'(st_time[i] - st_time[i-1]), (i == 3) ? 140 : 40);
    end

    // Reset while the first fetch is in flight: no row may appear.
    clear_log();
    pulse_start();
    n = 0;
    while (rom_addr !== '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("c_in_fetch", busy, 1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("c_row", row, 0);
    check("c_row_index", row_index, 0);
    check("c_row_valid", row_valid, 0);
    check("c_busy", busy, 0);
    check("c_done", done, 0);
    @(negedge clk);
    check("c_no_strobe", row_valid, 0);
`endif

    // Randomized soak with random ROM contents.
    resetn = 1'b0;
    @(negedge clk);
    for (int k = 0; k < CHART_LEN; k++) rom_mem[k] = 4'($urandom_range(0, 15));
    resetn = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      resetn = ($urandom_range(0, 599) != 0);
      start  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      @(negedge clk);
    end
    resetn = 1'b1;
    start  = 1'b0;
    pause  = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
